key_scan_ctrl: RTL and testbench

KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

---
 rtl/key_scan_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_key_scan_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_ctrl.sv
// 4x4 active-low key matrix scanner with press/release debounce.
// One row is driven low per row period; a debounced key is reported as row*4+col+1.
module key_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 10
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic [4:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        ST_SCAN = 2'd0,
        ST_PDEB = 2'd1,
        ST_HOLD = 2'd2,
        ST_RDEB = 2'd3
    } state_t;

    localparam logic [19:0] DIV_MAX = 20'(SCAN_DIV - 1);
    localparam logic [7:0]  DEB_LIM = 8'(DEB_CNT);

    // Lowest-numbered low column of a latched pattern wins.
    function automatic logic [1:0] low_col(input logic [3:0] pat);
        logic [1:0] idx;
        if (!pat[0]) begin
            idx = 2'd0;
        end else if (!pat[1]) begin
            idx = 2'd1;
        end else if (!pat[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] row);
        logic [1:0] idx;
        case (row)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [3:0]  col_meta_r;
    logic [3:0]  col_sync_r;
    logic [19:0] div_cnt_r;
    logic        tick_s;
    state_t      state_r,     state_nxt_s;
    logic [3:0]  row_r,       row_nxt_s;
    logic [7:0]  deb_cnt_r,   deb_cnt_nxt_s;
    logic [7:0]  deb_inc_s;
    logic [3:0]  pat_r,       pat_nxt_s;
    logic [1:0]  ridx_r,      ridx_nxt_s;
    logic [4:0]  key_code_r,  key_code_nxt_s;
    logic        key_valid_r, key_valid_nxt_s;
    logic        key_held_r,  key_held_nxt_s;

    assign tick_s    = (div_cnt_r == DIV_MAX);
    assign deb_inc_s = deb_cnt_r + 8'd1;

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            col_meta_r <= 4'hF;
            col_sync_r <= 4'hF;
        end else begin
            col_meta_r <= COL;
            col_sync_r <= col_meta_r;
        end
    end

    // Row period divider.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            div_cnt_r <= 20'd0;
        end else if (tick_s) begin
            div_cnt_r <= 20'd0;
        end else begin
            div_cnt_r <= div_cnt_r + 20'd1;
        end
    end

    // Next-state and output decode; decisions are only taken on a tick.
    always_comb begin
        state_nxt_s     = state_r;
        row_nxt_s       = row_r;
        deb_cnt_nxt_s   = deb_cnt_r;
        pat_nxt_s       = pat_r;
        ridx_nxt_s      = ridx_r;
        key_code_nxt_s  = key_code_r;
        key_valid_nxt_s = 1'b0;
        key_held_nxt_s  = key_held_r;
        if (tick_s) begin
            case (state_r)
                ST_SCAN: begin
                    if (col_sync_r == 4'hF) begin
                        row_nxt_s = {row_r[2:0], row_r[3]};
                    end else begin
                        pat_nxt_s     = col_sync_r;
                        ridx_nxt_s    = row_index(row_r);
                        deb_cnt_nxt_s = 8'd0;
                        state_nxt_s   = ST_PDEB;
                    end
                end
                ST_PDEB: begin
                    if (col_sync_r == pat_r) begin
                        deb_cnt_nxt_s = deb_inc_s;
                        if (deb_inc_s == DEB_LIM) begin
                            state_nxt_s     = ST_HOLD;
                            key_code_nxt_s  = {1'b0, ridx_r, low_col(pat_r)} + 5'd1;
                            key_valid_nxt_s = 1'b1;
                            key_held_nxt_s  = 1'b1;
                        end else begin
                            state_nxt_s = ST_PDEB;
                        end
                    end else begin
                        state_nxt_s = ST_SCAN;
                        row_nxt_s   = {row_r[2:0], row_r[3]};
                    end
                end
                ST_HOLD: begin
                    if (col_sync_r == 4'hF) begin
                        deb_cnt_nxt_s = 8'd0;
                        state_nxt_s   = ST_RDEB;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_RDEB: begin
                    if (col_sync_r == 4'hF) begin
                        deb_cnt_nxt_s = deb_inc_s;
                        if (deb_inc_s == DEB_LIM) begin
                            state_nxt_s    = ST_SCAN;
                            key_code_nxt_s = 5'd0;
                            key_held_nxt_s = 1'b0;
                            row_nxt_s      = {row_r[2:0], row_r[3]};
                        end else begin
                            state_nxt_s = ST_RDEB;
                        end
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    state_nxt_s    = ST_SCAN;
                    row_nxt_s      = 4'b1110;
                    deb_cnt_nxt_s  = 8'd0;
                    key_code_nxt_s = 5'd0;
                    key_held_nxt_s = 1'b0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_r     <= ST_SCAN;
            row_r       <= 4'b1110;
            deb_cnt_r   <= 8'd0;
            pat_r       <= 4'hF;
            ridx_r      <= 2'd0;
            key_code_r  <= 5'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            row_r       <= row_nxt_s;
            deb_cnt_r   <= deb_cnt_nxt_s;
            pat_r       <= pat_nxt_s;
            ridx_r      <= ridx_nxt_s;
            key_code_r  <= key_code_nxt_s;
            key_valid_r <= key_valid_nxt_s;
            key_held_r  <= key_held_nxt_s;
        end
    end

    assign ROW       = row_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed bench for key_scan_ctrl with SCAN_DIV=4, DEB_CNT=3 and a bench-side key matrix model.
module tb_key_scan_ctrl;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic [3:0] COL = 4'hF;
    logic [3:0] ROW;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_held;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int valid_cnt = 0;
    logic [15:0] keys = 16'h0000;
    logic [3:0] exp_rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    key_scan_ctrl #(.SCAN_DIV(4), .DEB_CNT(3)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .COL(COL), .ROW(ROW),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 HCLK = ~HCLK;

    // Pressed keys short the driven-low row onto their column.
    task automatic update_col();
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (ROW[r] === 1'b0) begin
                for (int k = 0; k < 4; k++) begin
                    if (keys[r*4+k]) c[k] = 1'b0;
                end
            end
        end
        COL = c;
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
        if (HRESET) cyc = 0;
        else cyc++;
        update_col();
        if (key_valid === 1'b1) valid_cnt++;
        checks++;
        if (ROW !== 4'b1110 && ROW !== 4'b1101 && ROW !== 4'b1011 && ROW !== 4'b0111) begin
            errors++;
            $display("FAIL row_onehot: got %b at cycle %0d", ROW, cyc);
        end
    endtask

    // Advance until n divider ticks have been consumed by the DUT.
    task automatic run_ticks(input int n);
        int seen;
        int guard;
        seen = 0;
        guard = 0;
        while (seen < n && guard < 1000) begin
            step();
            guard++;
            if (cyc > 0 && (cyc % 4) == 0) seen++;
        end
    endtask

    task automatic do_reset(input logic [15:0] k);
        keys = k;
        HRESET = 1'b1;
        step();
        step();
        HRESET = 1'b0;
        valid_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset(16'h0000);
        checks++; if (ROW !== 4'b1110) begin errors++; $display("FAIL rst_row: got %b want 1110", ROW); end
        checks++; if (key_code !== 5'd0) begin errors++; $display("FAIL rst_code: got %0d want 0", key_code); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", key_valid); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rst_held: got %b want 0", key_held); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (ROW !== 4'b1110) begin errors++; $display("FAIL rst_first_tick_early: got %b want 1110", ROW); end
        step();
        checks++; if (ROW !== 4'b1101) begin errors++; $display("FAIL rst_first_tick: got %b want 1101", ROW); end
        for (int g = 1; g <= 8; g++) begin
            for (int i = 0; i < 4; i++) step();
            checks++;
            if (ROW !== exp_rows[(g + 1) % 4]) begin
                errors++;
                $display("FAIL scan_rotate[%0d]: got %b want %b", g, ROW, exp_rows[(g + 1) % 4]);
            end
        end
        checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL scan_no_valid: got %0d want 0", valid_cnt); end
        checks++; if (key_code !== 5'd0) begin errors++; $display("FAIL scan_code: got %0d want 0", key_code); end
    endtask

    task automatic test_press_release();
        do_reset(16'h0040);
        run_ticks(4);
        checks++; if (key_held !== 1'b0 || key_code !== 5'd0) begin errors++; $display("FAIL pdeb_early: held=%b code=%0d want 0/0", key_held, key_code); end
        checks++; if (ROW !== 4'b1101) begin errors++; $display("FAIL pdeb_row_frozen: got %b want 1101", ROW); end
        run_ticks(1);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL press_valid: got %b want 1", key_valid); end
        checks++; if (key_code !== 5'd7) begin errors++; $display("FAIL press_code: got %0d want 7", key_code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b want 1", key_held); end
        step();
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b want 0", key_valid); end
        keys = 16'h0000;
        update_col();
        run_ticks(3);
        checks++; if (key_held !== 1'b1 || key_code !== 5'd7) begin errors++; $display("FAIL rdeb_early: held=%b code=%0d want 1/7", key_held, key_code); end
        run_ticks(1);
        checks++; if (key_held !== 1'b0 || key_code !== 5'd0) begin errors++; $display("FAIL release: held=%b code=%0d want 0/0", key_held, key_code); end
        checks++; if (ROW !== 4'b1011) begin errors++; $display("FAIL release_row: got %b want 1011", ROW); end
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL press_valid_cnt: got %0d want 1", valid_cnt); end
    endtask

    task automatic test_bounce();
        do_reset(16'h0040);
        run_ticks(2);
        keys = 16'h0000;
        update_col();
        checks++; if (ROW !== 4'b1101) begin errors++; $display("FAIL bounce_frozen: got %b want 1101", ROW); end
        run_ticks(1);
        checks++; if (ROW !== 4'b1011) begin errors++; $display("FAIL bounce_row: got %b want 1011", ROW); end
        run_ticks(4);
        checks++; if (ROW !== 4'b1011) begin errors++; $display("FAIL bounce_rescan: got %b want 1011", ROW); end
        checks++; if (valid_cnt !== 0 || key_held !== 1'b0 || key_code !== 5'd0) begin
            errors++; $display("FAIL bounce_nokey: valid_cnt=%0d held=%b code=%0d want 0/0/0", valid_cnt, key_held, key_code);
        end
    endtask

    task automatic test_multi_key();
        do_reset(16'h0003);
        run_ticks(4);
        checks++; if (key_valid !== 1'b1 || key_code !== 5'd1) begin errors++; $display("FAIL multi_code: valid=%b code=%0d want 1/1", key_valid, key_code); end
        keys = 16'h0803;
        update_col();
        run_ticks(6);
        checks++; if (key_code !== 5'd1 || key_held !== 1'b1) begin errors++; $display("FAIL second_key_code: code=%0d held=%b want 1/1", key_code, key_held); end
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL second_key_valid: got %0d want 1", valid_cnt); end
        checks++; if (ROW !== 4'b1110) begin errors++; $display("FAIL hold_row: got %b want 1110", ROW); end
    endtask

    task automatic test_release_glitch();
        do_reset(16'h0001);
        run_ticks(4);
        checks++; if (key_code !== 5'd1) begin errors++; $display("FAIL glitch_press: got %0d want 1", key_code); end
        keys = 16'h0000;
        update_col();
        run_ticks(2);
        keys = 16'h0001;
        update_col();
        run_ticks(1);
        checks++; if (key_held !== 1'b1 || key_code !== 5'd1) begin errors++; $display("FAIL glitch_hold: held=%b code=%0d want 1/1", key_held, key_code); end
        keys = 16'h0000;
        update_col();
        run_ticks(3);
        checks++; if (key_held !== 1'b1 || key_code !== 5'd1) begin errors++; $display("FAIL glitch_restart: held=%b code=%0d want 1/1", key_held, key_code); end
        run_ticks(1);
        checks++; if (key_held !== 1'b0 || key_code !== 5'd0 || ROW !== 4'b1101) begin
            errors++; $display("FAIL glitch_release: held=%b code=%0d row=%b want 0/0/1101", key_held, key_code, ROW);
        end
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL glitch_valid_cnt: got %0d want 1", valid_cnt); end
    endtask

    task automatic test_reset_in_hold();
        do_reset(16'h0001);
        run_ticks(4);
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL hold_entry: got %b want 1", key_held); end
        step();
        keys = 16'h0000;
        update_col();
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        checks++; if (key_code !== 5'd0 || key_held !== 1'b0 || key_valid !== 1'b0) begin
            errors++; $display("FAIL hold_reset_out: code=%0d held=%b valid=%b want 0/0/0", key_code, key_held, key_valid);
        end
        checks++; if (ROW !== 4'b1110) begin errors++; $display("FAIL hold_reset_row: got %b want 1110", ROW); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (ROW !== 4'b1110) begin errors++; $display("FAIL post_reset_early: got %b want 1110", ROW); end
        step();
        checks++; if (ROW !== 4'b1101) begin errors++; $display("FAIL post_reset_tick: got %b want 1101", ROW); end
        checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL hold_reset_valid_cnt: got %0d want 1", valid_cnt); end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_multi_key();
        test_release_glitch();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
